// File: rtl/disp_arb_pkg.sv
// Shared encodings for the display arbiter: FSM states and one-hot view selects.
package disp_arb_pkg;

  typedef enum logic [1:0] {
    ST_CLOCK  = 2'd0,
    ST_ALARM  = 2'd1,
    ST_SWATCH = 2'd2,
    ST_RING   = 2'd3
  } state_t;

  localparam logic [2:0] SEL_C    = 3'b001;
  localparam logic [2:0] SEL_A    = 3'b010;
  localparam logic [2:0] SEL_S    = 3'b100;
  localparam logic [2:0] SEL_NONE = 3'b000;

endpackage

// File: rtl/disp_timeout.sv
// Idle timer for the alarm view: counts 1 Hz ticks and flags expiry on the tick that reaches TIMEOUT.
module disp_timeout #(
  parameter int TIMEOUT = 10,
  parameter int TO_W    = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic tick,
  output logic expired
);

  localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT);
  localparam logic [TO_W-1:0] LAST  = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] cnt;

  // Saturating counter; clear wins over a coincident tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (tick && (cnt != LIMIT)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Fire in the same cycle as the reaching tick so the FSM can weigh it against MODE.
  assign expired = !clr && ((tick && (cnt == LAST)) || (cnt == LIMIT));

endmodule

// File: rtl/disp_arbiter.sv
// Arbitrates the shared 7-seg display between clock, alarm-set and stopwatch views,
// with an alarm-ring override that flashes the clock time.
module disp_arbiter
  import disp_arb_pkg::*;
#(
  parameter int TIMEOUT = 10,
  parameter int TO_W    = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        MODE,
  input  logic        ACT,
  input  logic        EN1HZ,
  input  logic        SIG2HZ,
  input  logic        ALARM_RING,
  input  logic [15:0] C_DIG,
  input  logic [3:0]  C_DP,
  input  logic [3:0]  C_EN,
  input  logic [15:0] A_DIG,
  input  logic [3:0]  A_DP,
  input  logic [3:0]  A_EN,
  input  logic [15:0] S_DIG,
  input  logic [3:0]  S_DP,
  input  logic [3:0]  S_EN,
  output logic [15:0] DIG,
  output logic [3:0]  DP,
  output logic [3:0]  EN,
  output logic [2:0]  SEL,
  output logic        RING_ACK
);

  state_t state, nxt;
  state_t saved, saved_nxt;
  logic   ack_nxt;
  logic   expired;
  logic   to_clr;

  logic [15:0] dig_nxt;
  logic [3:0]  dp_nxt;
  logic [3:0]  en_nxt;
  logic [2:0]  sel_nxt;

  // Outside the alarm view the timer is held clear, so every entry starts from zero.
  assign to_clr = ACT || (state != ST_ALARM);

  disp_timeout #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_timeout (
    .clk     (CLK),
    .rst     (RST),
    .clr     (to_clr),
    .tick    (EN1HZ),
    .expired (expired)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= ST_CLOCK;
      saved    <= ST_CLOCK;
      RING_ACK <= 1'b0;
    end else begin
      state    <= nxt;
      saved    <= saved_nxt;
      RING_ACK <= ack_nxt;
    end
  end

  // Priority: ALARM_RING, then MODE, then timeout.
  always_comb begin
    nxt       = state;
    saved_nxt = saved;
    ack_nxt   = 1'b0;
    case (state)
      ST_CLOCK: begin
        if (ALARM_RING) begin
          nxt       = ST_RING;
          saved_nxt = ST_CLOCK;
        end else if (MODE) begin
          nxt = ST_ALARM;
        end
      end
      ST_ALARM: begin
        if (ALARM_RING) begin
          nxt       = ST_RING;
          saved_nxt = ST_ALARM;
        end else if (MODE) begin
          nxt = ST_SWATCH;
        end else if (expired) begin
          nxt = ST_CLOCK;
        end
      end
      ST_SWATCH: begin
        if (ALARM_RING) begin
          nxt       = ST_RING;
          saved_nxt = ST_SWATCH;
        end else if (MODE) begin
          nxt = ST_CLOCK;
        end
      end
      ST_RING: begin
        ack_nxt = MODE;
        if (!ALARM_RING) begin
          nxt = saved;
        end
      end
      default: nxt = ST_CLOCK;
    endcase
  end

  // Source selection follows the next state so a view switch lands one cycle after MODE.
  always_comb begin
    dig_nxt = C_DIG;
    dp_nxt  = C_DP;
    en_nxt  = C_EN;
    sel_nxt = SEL_C;
    case (nxt)
      ST_ALARM: begin
        dig_nxt = A_DIG;
        dp_nxt  = A_DP;
        en_nxt  = A_EN;
        sel_nxt = SEL_A;
      end
      ST_SWATCH: begin
        dig_nxt = S_DIG;
        dp_nxt  = S_DP;
        en_nxt  = S_EN;
        sel_nxt = SEL_S;
      end
      ST_RING: begin
        en_nxt  = C_EN & {4{SIG2HZ}};
        sel_nxt = SEL_NONE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      DIG <= '0;
      DP  <= '0;
      EN  <= '0;
      SEL <= SEL_C;
    end else begin
      DIG <= dig_nxt;
      DP  <= dp_nxt;
      EN  <= en_nxt;
      SEL <= sel_nxt;
    end
  end

endmodule
